// File: rtl/lifo_edge_detect.sv
// Rising-edge qualifier for a level strobe: one pulse per assertion.
// The strobe must be sampled low on at least one edge before it can fire again.

module lifo_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic strobe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign pulse = strobe & ~strobe_q;

endmodule

// File: rtl/lifo.sv
// Parameterized LIFO stack with edge-qualified push/pop strobes and a registered pop output.
// A simultaneous push and pop on a non-empty stack swaps the top entry.

module lifo #(
    parameter int Input_Data_Width = 8,
    parameter int LIFO_Depth       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Write,
    input  logic                        Read,
    input  logic [Input_Data_Width-1:0] Data_in,
    output logic [Input_Data_Width-1:0] Data_out,
    output logic                        LIFO_Full,
    output logic                        LIFO_Empty
);

    localparam int CntW = $clog2(LIFO_Depth + 1);
    localparam int AddrW = $clog2(LIFO_Depth);
    localparam logic [CntW-1:0] DepthCnt = CntW'(LIFO_Depth);

    logic [Input_Data_Width-1:0] mem [LIFO_Depth];
    logic [CntW-1:0]             count;
    logic [CntW-1:0]             count_d;
    logic [Input_Data_Width-1:0] data_out_d;
    logic                        push_req;
    logic                        pop_req;
    logic                        do_push;
    logic                        do_pop;
    logic                        do_swap;
    logic                        mem_we;
    logic [AddrW-1:0]            wr_addr;
    logic [AddrW-1:0]            rd_addr;

    lifo_edge_detect u_write_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (Write),
        .pulse  (push_req)
    );

    lifo_edge_detect u_read_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (Read),
        .pulse  (pop_req)
    );

    assign LIFO_Empty = (count == '0);
    assign LIFO_Full  = (count == DepthCnt);

    always_comb begin
        // Swap is legal even when full; push+pop on empty degrades to a plain push.
        do_swap    = push_req & pop_req & ~LIFO_Empty;
        do_push    = push_req & ~do_swap & ~LIFO_Full;
        do_pop     = pop_req & ~push_req & ~LIFO_Empty;
        mem_we     = do_push | do_swap;
        rd_addr    = AddrW'(count - 1'b1);
        wr_addr    = do_swap ? rd_addr : AddrW'(count);
        count_d    = count;
        data_out_d = Data_out;
        if (do_push) begin
            count_d = count + 1'b1;
        end else if (do_pop) begin
            count_d = count - 1'b1;
        end
        if (do_pop || do_swap) begin
            data_out_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            Data_out <= '0;
        end else begin
            count    <= count_d;
            Data_out <= data_out_d;
        end
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= Data_in;
        end
    end

endmodule

// File: tb/tb_lifo.sv
// Self-checking bench for lifo: directed scenarios, a vector table and a randomized run
// checked against a queue-based reference stack.

module tb_lifo;

    localparam int W = 8;
    localparam int D = 13;

    logic         clk = 1'b0;
    logic         reset;
    logic         Write;
    logic         Read;
    logic [W-1:0] Data_in;
    logic [W-1:0] Data_out;
    logic         LIFO_Full;
    logic         LIFO_Empty;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_out;
    logic         m_wr;
    logic         m_rd;

    typedef struct {
        logic         w;
        logic         r;
        logic [W-1:0] d;
        logic [W-1:0] out;
        int           cnt;
    } vec_t;

    vec_t vecs[$];

    lifo #(
        .Input_Data_Width (W),
        .LIFO_Depth       (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Write      (Write),
        .Read       (Read),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .LIFO_Full  (LIFO_Full),
        .LIFO_Empty (LIFO_Empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("data_out", int'(Data_out), int'(m_out));
        check("full", int'(LIFO_Full), int'(mq.size() == D));
        check("empty", int'(LIFO_Empty), int'(mq.size() == 0));
        check("count", int'(dut.count), mq.size());
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        logic push;
        logic pop;
        Write   = w;
        Read    = r;
        Data_in = d;
        @(posedge clk);
        push = w & ~m_wr;
        pop  = r & ~m_rd;
        m_wr = w;
        m_rd = r;
        if (push && pop) begin
            if (mq.size() > 0) begin
                m_out = mq[$];
                mq[$] = d;
            end else begin
                mq.push_back(d);
            end
        end else if (push) begin
            if (mq.size() < D) mq.push_back(d);
        end else if (pop) begin
            if (mq.size() > 0) m_out = mq.pop_back();
        end
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        mq.delete();
        m_out = '0;
        m_wr  = 1'b0;
        m_rd  = 1'b0;
        check("rst_count", int'(dut.count), 0);
        check("rst_empty", int'(LIFO_Empty), 1);
        check("rst_full", int'(LIFO_Full), 0);
        check("rst_data_out", int'(Data_out), 0);
        #1;
        reset = 1'b1;
    endtask

    function automatic void add(input logic w, input logic r, input logic [W-1:0] d,
                                input logic [W-1:0] out, input int cnt);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.out = out; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] fill[D];
        fill = '{110, 22, 80, 60, 94, 123, 45, 12, 33, 210, 6, 35, 20};
        m_out = '0; m_wr = 1'b0; m_rd = 1'b0;

        // Write held high across reset release pushes once at the first edge.
        Write = 1'b1; Read = 1'b0; Data_in = 8'd10;
        apply_reset();
        repeat (3) step(1'b1, 1'b0, 8'd10);
        step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd20);
        step(1'b0, 1'b0, 8'd0);
        check("s1_count", int'(dut.count), 2);
        step(1'b1, 1'b0, 8'd30);
        apply_reset();

        // Fill to full, then overflow pushes are ignored.
        for (int i = 0; i < D; i++) begin
            step(1'b1, 1'b0, fill[i]);
            step(1'b0, 1'b0, 8'd0);
        end
        check("s2_full", int'(LIFO_Full), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(75 + i));
            step(1'b0, 1'b0, 8'd0);
        end
        check("s2_count", int'(dut.count), D);

        // Drain in reverse order.
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("s3_pop", int'(Data_out), int'(fill[D-1-i]));
            step(1'b0, 1'b0, 8'd0);
        end
        check("s3_empty", int'(LIFO_Empty), 1);

        // Held Read pops once; pops on empty leave Data_out alone.
        step(1'b1, 1'b0, 8'd110);
        step(1'b0, 1'b0, 8'd0);
        repeat (4) step(1'b0, 1'b1, 8'd0);
        check("s4_held_pop", int'(Data_out), 110);
        check("s4_count", int'(dut.count), 0);
        step(1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'd0);
            step(1'b0, 1'b0, 8'd0);
        end
        check("s4_hold", int'(Data_out), 110);

        // Interleaved push/pop and top-entry swap from a vector table.
        apply_reset();
        add(1, 0, 6, 0, 1);    add(0, 0, 0, 0, 1);
        add(1, 0, 7, 0, 2);    add(0, 0, 0, 0, 2);
        add(1, 0, 22, 0, 3);   add(0, 0, 0, 0, 3);
        add(1, 0, 2, 0, 4);    add(0, 0, 0, 0, 4);
        add(0, 1, 0, 2, 3);    add(0, 0, 0, 2, 3);
        add(0, 1, 0, 22, 2);   add(0, 0, 0, 22, 2);
        add(1, 0, 44, 22, 3);  add(0, 0, 0, 22, 3);
        add(1, 0, 60, 22, 4);  add(0, 0, 0, 22, 4);
        add(0, 1, 0, 60, 3);   add(0, 0, 0, 60, 3);
        add(0, 1, 0, 44, 2);   add(0, 0, 0, 44, 2);
        add(1, 1, 9, 7, 2);    add(0, 0, 0, 7, 2);
        add(0, 1, 0, 9, 1);    add(0, 0, 0, 9, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].w, vecs[i].r, vecs[i].d);
            check($sformatf("vec%0d_out", i), int'(Data_out), int'(vecs[i].out));
            check($sformatf("vec%0d_cnt", i), int'(dut.count), vecs[i].cnt);
        end

        // Randomized traffic: push-heavy phase then pop-heavy phase, with sporadic resets.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 79) == 0) begin
                    @(negedge clk);
                    apply_reset();
                end else begin
                    step(1'($urandom_range(0, 9) < (ph == 0 ? 6 : 3)),
                         1'($urandom_range(0, 9) < (ph == 0 ? 3 : 6)),
                         8'($urandom));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
